// File: rtl/raifes_hasti_arbiter.sv
// N-master to one-slave AHB-Lite arbiter with fixed-priority or round-robin selection,
// per-master hold registers for stalled address phases, and locked-sequence support.
module raifes_hasti_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ARB_MODE  = 1,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_MASTERS*AW-1:0] m_haddr,
  input  logic [N_MASTERS-1:0]    m_hwrite,
  input  logic [N_MASTERS*3-1:0]  m_hsize,
  input  logic [N_MASTERS*2-1:0]  m_htrans,
  input  logic [N_MASTERS-1:0]    m_hmastlock,
  input  logic [N_MASTERS*DW-1:0] m_hwdata,
  output logic [DW-1:0]           m_hrdata,
  output logic [N_MASTERS-1:0]    m_hready,
  output logic [N_MASTERS-1:0]    m_hresp,
  output logic [AW-1:0]           s_haddr,
  output logic                    s_hwrite,
  output logic [2:0]              s_hsize,
  output logic [1:0]              s_htrans,
  output logic                    s_hmastlock,
  output logic [DW-1:0]           s_hwdata,
  input  logic [DW-1:0]           s_hrdata,
  input  logic                    s_hready,
  input  logic                    s_hresp
);

  localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(N_MASTERS - 1);

  logic [1:0]           state      [N_MASTERS];
  logic [AW-1:0]        hold_addr  [N_MASTERS];
  logic [2:0]           hold_size  [N_MASTERS];
  logic [1:0]           hold_trans [N_MASTERS];
  logic [N_MASTERS-1:0] hold_write;
  logic [N_MASTERS-1:0] hold_lock;

  logic [N_MASTERS-1:0] held;
  logic [N_MASTERS-1:0] in_data;
  logic [N_MASTERS-1:0] live;
  logic [N_MASTERS-1:0] cand;

  logic [AW-1:0]        req_addr  [N_MASTERS];
  logic [2:0]           req_size  [N_MASTERS];
  logic [1:0]           req_trans [N_MASTERS];
  logic [N_MASTERS-1:0] req_write;
  logic [N_MASTERS-1:0] req_lock;

  logic          owner_valid;
  logic [IW-1:0] owner_idx;
  logic [IW-1:0] last_grant;
  logic          lock_valid;
  logic [IW-1:0] lock_idx;

  logic          arb_en;
  logic          lock_hold;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] rr_sel;

  assign arb_en   = s_hready & reset;
  assign m_hrdata = s_hrdata;

  // A held master presents its captured request; everyone else presents live inputs.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      held[i]      = (state[i] == ST_HELD);
      in_data[i]   = (state[i] == ST_DATA);
      m_hready[i]  = in_data[i] ? s_hready : ~held[i];
      m_hresp[i]   = in_data[i] & s_hresp;
      live[i]      = m_htrans[2*i+1] & m_hready[i];
      cand[i]      = held[i] | live[i];
      req_addr[i]  = held[i] ? hold_addr[i]  : m_haddr[i*AW +: AW];
      req_size[i]  = held[i] ? hold_size[i]  : m_hsize[i*3 +: 3];
      req_trans[i] = held[i] ? hold_trans[i] : m_htrans[i*2 +: 2];
      req_write[i] = held[i] ? hold_write[i] : m_hwrite[i];
      req_lock[i]  = held[i] ? hold_lock[i]  : m_hmastlock[i];
    end
  end

  // Descending loops let the first candidate in search order overwrite the rest.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_sel      = '0;
    lock_hold   = lock_valid & cand[lock_idx] & req_lock[lock_idx];
    if (arb_en) begin
      if (lock_hold) begin
        grant_valid = 1'b1;
        grant_idx   = lock_idx;
      end else if (ARB_MODE == 0) begin
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
          if (cand[i]) begin
            grant_valid = 1'b1;
            grant_idx   = IW'(i);
          end
        end
      end else begin
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
          rr_sel = IW'((int'(last_grant) + 1 + k) % N_MASTERS);
          if (cand[rr_sel]) begin
            grant_valid = 1'b1;
            grant_idx   = rr_sel;
          end
        end
      end
    end
  end

  always_comb begin
    s_haddr     = '0;
    s_hwrite    = 1'b0;
    s_hsize     = 3'b000;
    s_htrans    = 2'b00;
    s_hmastlock = 1'b0;
    if (grant_valid) begin
      s_haddr     = req_addr[grant_idx];
      s_hwrite    = req_write[grant_idx];
      s_hsize     = req_size[grant_idx];
      s_htrans    = req_trans[grant_idx];
      s_hmastlock = req_lock[grant_idx];
    end
  end

  always_comb begin
    s_hwdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (owner_valid && (owner_idx == IW'(i))) begin
        s_hwdata = m_hwdata[i*DW +: DW];
      end
    end
  end

  // Losing or stalled live requests are captured so the master sees an accepted address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        state[i]      <= ST_IDLE;
        hold_addr[i]  <= '0;
        hold_size[i]  <= 3'b000;
        hold_trans[i] <= 2'b00;
      end
      hold_write <= '0;
      hold_lock  <= '0;
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (grant_valid && (grant_idx == IW'(i))) begin
          state[i] <= ST_DATA;
        end else if (live[i]) begin
          state[i]      <= ST_HELD;
          hold_addr[i]  <= m_haddr[i*AW +: AW];
          hold_size[i]  <= m_hsize[i*3 +: 3];
          hold_trans[i] <= m_htrans[i*2 +: 2];
          hold_write[i] <= m_hwrite[i];
          hold_lock[i]  <= m_hmastlock[i];
        end else if (in_data[i] && s_hready) begin
          state[i] <= ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_valid <= 1'b0;
      owner_idx   <= '0;
      last_grant  <= LAST_IDX;
      lock_valid  <= 1'b0;
      lock_idx    <= '0;
    end else if (s_hready) begin
      owner_valid <= grant_valid;
      owner_idx   <= grant_idx;
      lock_valid  <= grant_valid & req_lock[grant_idx];
      lock_idx    <= grant_idx;
      if (grant_valid) begin
        last_grant <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_raifes_hasti_arbiter.sv
// Drives a fixed-priority (4 masters) and a round-robin (3 masters) arbiter side by side
// and compares every cycle against a request-queue reference model.
module tb_raifes_hasti_arbiter;

  localparam int MAXN = 4;
  localparam int NA   = 4;
  localparam int NB   = 3;
  localparam int NM [2] = '{NA, NB};
  localparam int MD [2] = '{0, 1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] in_addr  [2][MAXN];
  logic        in_write [2][MAXN];
  logic [2:0]  in_size  [2][MAXN];
  logic [1:0]  in_trans [2][MAXN];
  logic        in_lock  [2][MAXN];
  logic [31:0] in_wdata [2][MAXN];
  logic [31:0] sl_rdata [2];
  logic        sl_ready [2];
  logic        sl_resp  [2];

  logic [NA*32-1:0] a_haddr, a_hwdata;
  logic [NA-1:0]    a_hwrite, a_hlock, a_m_hready, a_m_hresp;
  logic [NA*3-1:0]  a_hsize;
  logic [NA*2-1:0]  a_htrans;
  logic [31:0]      a_m_hrdata, a_s_haddr, a_s_hwdata;
  logic             a_s_hwrite, a_s_hmastlock;
  logic [2:0]       a_s_hsize;
  logic [1:0]       a_s_htrans;

  logic [NB*32-1:0] b_haddr, b_hwdata;
  logic [NB-1:0]    b_hwrite, b_hlock, b_m_hready, b_m_hresp;
  logic [NB*3-1:0]  b_hsize;
  logic [NB*2-1:0]  b_htrans;
  logic [31:0]      b_m_hrdata, b_s_haddr, b_s_hwdata;
  logic             b_s_hwrite, b_s_hmastlock;
  logic [2:0]       b_s_hsize;
  logic [1:0]       b_s_htrans;

  for (genvar i = 0; i < NA; i++) begin : g_pack_a
    assign a_haddr[i*32 +: 32]  = in_addr[0][i];
    assign a_hwdata[i*32 +: 32] = in_wdata[0][i];
    assign a_hwrite[i]          = in_write[0][i];
    assign a_hlock[i]           = in_lock[0][i];
    assign a_hsize[i*3 +: 3]    = in_size[0][i];
    assign a_htrans[i*2 +: 2]   = in_trans[0][i];
  end

  for (genvar i = 0; i < NB; i++) begin : g_pack_b
    assign b_haddr[i*32 +: 32]  = in_addr[1][i];
    assign b_hwdata[i*32 +: 32] = in_wdata[1][i];
    assign b_hwrite[i]          = in_write[1][i];
    assign b_hlock[i]           = in_lock[1][i];
    assign b_hsize[i*3 +: 3]    = in_size[1][i];
    assign b_htrans[i*2 +: 2]   = in_trans[1][i];
  end

  raifes_hasti_arbiter #(.N_MASTERS(NA), .ARB_MODE(0), .AW(32), .DW(32)) dut_fixed (
    .clk(clk), .reset(rst_n),
    .m_haddr(a_haddr), .m_hwrite(a_hwrite), .m_hsize(a_hsize), .m_htrans(a_htrans),
    .m_hmastlock(a_hlock), .m_hwdata(a_hwdata), .m_hrdata(a_m_hrdata),
    .m_hready(a_m_hready), .m_hresp(a_m_hresp),
    .s_haddr(a_s_haddr), .s_hwrite(a_s_hwrite), .s_hsize(a_s_hsize), .s_htrans(a_s_htrans),
    .s_hmastlock(a_s_hmastlock), .s_hwdata(a_s_hwdata),
    .s_hrdata(sl_rdata[0]), .s_hready(sl_ready[0]), .s_hresp(sl_resp[0])
  );

  raifes_hasti_arbiter #(.N_MASTERS(NB), .ARB_MODE(1), .AW(32), .DW(32)) dut_rr (
    .clk(clk), .reset(rst_n),
    .m_haddr(b_haddr), .m_hwrite(b_hwrite), .m_hsize(b_hsize), .m_htrans(b_htrans),
    .m_hmastlock(b_hlock), .m_hwdata(b_hwdata), .m_hrdata(b_m_hrdata),
    .m_hready(b_m_hready), .m_hresp(b_m_hresp),
    .s_haddr(b_s_haddr), .s_hwrite(b_s_hwrite), .s_hsize(b_s_hsize), .s_htrans(b_s_htrans),
    .s_hmastlock(b_s_hmastlock), .s_hwdata(b_s_hwdata),
    .s_hrdata(sl_rdata[1]), .s_hready(sl_ready[1]), .s_hresp(sl_resp[1])
  );

  logic [1:0]      obs_trans [2];
  logic [31:0]     obs_addr  [2];
  logic [31:0]     obs_wdata [2];
  logic [31:0]     obs_rdata [2];
  logic            obs_write [2];
  logic            obs_lock  [2];
  logic [2:0]      obs_size  [2];
  logic [MAXN-1:0] obs_rdy   [2];
  logic [MAXN-1:0] obs_resp  [2];

  assign obs_trans[0] = a_s_htrans;    assign obs_trans[1] = b_s_htrans;
  assign obs_addr[0]  = a_s_haddr;     assign obs_addr[1]  = b_s_haddr;
  assign obs_wdata[0] = a_s_hwdata;    assign obs_wdata[1] = b_s_hwdata;
  assign obs_rdata[0] = a_m_hrdata;    assign obs_rdata[1] = b_m_hrdata;
  assign obs_write[0] = a_s_hwrite;    assign obs_write[1] = b_s_hwrite;
  assign obs_lock[0]  = a_s_hmastlock; assign obs_lock[1]  = b_s_hmastlock;
  assign obs_size[0]  = a_s_hsize;     assign obs_size[1]  = b_s_hsize;
  assign obs_rdy[0]   = a_m_hready;    assign obs_rdy[1]   = {1'b0, b_m_hready};
  assign obs_resp[0]  = a_m_hresp;     assign obs_resp[1]  = {1'b0, b_m_hresp};

  // Reference model: a set of pending (held) requests plus one data-phase owner per slave.
  int          owner    [2];
  int          last     [2];
  int          lock_own [2];
  bit          held     [2][MAXN];
  logic [31:0] h_addr   [2][MAXN];
  logic        h_write  [2][MAXN];
  logic [2:0]  h_size   [2][MAXN];
  logic [1:0]  h_trans  [2][MAXN];
  logic        h_lock   [2][MAXN];
  bit          exp_rdy  [2][MAXN];

  int n_cmp = 0;
  int n_err = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset(input int u);
    owner[u]    = -1;
    last[u]     = NM[u] - 1;
    lock_own[u] = -1;
    for (int i = 0; i < MAXN; i++) begin
      held[u][i]    = 1'b0;
      h_addr[u][i]  = '0;
      h_write[u][i] = 1'b0;
      h_size[u][i]  = '0;
      h_trans[u][i] = '0;
      h_lock[u][i]  = 1'b0;
      exp_rdy[u][i] = 1'b1;
    end
  endtask

  task automatic modelCheck(input int u);
    logic [MAXN-1:0] rdy, resp;
    bit          live [MAXN];
    bit          cand [MAXN];
    logic [31:0] q_addr  [MAXN];
    logic        q_write [MAXN];
    logic [2:0]  q_size  [MAXN];
    logic [1:0]  q_trans [MAXN];
    logic        q_lock  [MAXN];
    int    n, w, idx;
    string p;
    p = (u == 0) ? "fixed" : "rr";
    n = NM[u];
    if (!rst_n) begin
      model_reset(u);
      checkOutput({p, ".rst.s_htrans"}, 32'(obs_trans[u]), 32'h0);
      checkOutput({p, ".rst.s_haddr"}, obs_addr[u], 32'h0);
      checkOutput({p, ".rst.s_hwrite"}, 32'(obs_write[u]), 32'h0);
      checkOutput({p, ".rst.s_hsize"}, 32'(obs_size[u]), 32'h0);
      checkOutput({p, ".rst.s_hmastlock"}, 32'(obs_lock[u]), 32'h0);
      checkOutput({p, ".rst.s_hwdata"}, obs_wdata[u], 32'h0);
      checkOutput({p, ".rst.m_hready"}, 32'(obs_rdy[u]), (32'h1 << n) - 32'h1);
      checkOutput({p, ".rst.m_hresp"}, 32'(obs_resp[u]), 32'h0);
      return;
    end
    rdy  = '0;
    resp = '0;
    for (int i = 0; i < MAXN; i++) begin
      live[i] = 1'b0; cand[i] = 1'b0; q_addr[i] = '0; q_write[i] = 1'b0;
      q_size[i] = '0; q_trans[i] = '0; q_lock[i] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      rdy[i]     = held[u][i] ? 1'b0 : ((owner[u] == i) ? sl_ready[u] : 1'b1);
      resp[i]    = (owner[u] == i) && sl_resp[u];
      live[i]    = in_trans[u][i][1] && rdy[i];
      cand[i]    = held[u][i] || live[i];
      q_addr[i]  = held[u][i] ? h_addr[u][i]  : in_addr[u][i];
      q_write[i] = held[u][i] ? h_write[u][i] : in_write[u][i];
      q_size[i]  = held[u][i] ? h_size[u][i]  : in_size[u][i];
      q_trans[i] = held[u][i] ? h_trans[u][i] : in_trans[u][i];
      q_lock[i]  = held[u][i] ? h_lock[u][i]  : in_lock[u][i];
    end
    w = -1;
    if (sl_ready[u]) begin
      if (lock_own[u] >= 0 && cand[lock_own[u]] && q_lock[lock_own[u]]) begin
        w = lock_own[u];
      end else begin
        for (int k = 0; k < n; k++) begin
          idx = (MD[u] == 0) ? k : (last[u] + 1 + k) % n;
          if (cand[idx]) begin
            w = idx;
            break;
          end
        end
      end
    end
    checkOutput({p, ".s_htrans"}, 32'(obs_trans[u]), (w >= 0) ? 32'(q_trans[w]) : 32'h0);
    if (w >= 0) begin
      checkOutput({p, ".s_haddr"}, obs_addr[u], q_addr[w]);
      checkOutput({p, ".s_hwrite"}, 32'(obs_write[u]), 32'(q_write[w]));
      checkOutput({p, ".s_hsize"}, 32'(obs_size[u]), 32'(q_size[w]));
      checkOutput({p, ".s_hmastlock"}, 32'(obs_lock[u]), 32'(q_lock[w]));
    end
    checkOutput({p, ".m_hready"}, 32'(obs_rdy[u]), 32'(rdy));
    checkOutput({p, ".m_hresp"}, 32'(obs_resp[u]), 32'(resp));
    checkOutput({p, ".s_hwdata"}, obs_wdata[u], (owner[u] >= 0) ? in_wdata[u][owner[u]] : 32'h0);
    checkOutput({p, ".m_hrdata"}, obs_rdata[u], sl_rdata[u]);
    for (int i = 0; i < n; i++) begin
      exp_rdy[u][i] = rdy[i];
      if (i == w) begin
        held[u][i] = 1'b0;
      end else if (live[i]) begin
        held[u][i]    = 1'b1;
        h_addr[u][i]  = in_addr[u][i];
        h_write[u][i] = in_write[u][i];
        h_size[u][i]  = in_size[u][i];
        h_trans[u][i] = in_trans[u][i];
        h_lock[u][i]  = in_lock[u][i];
      end
    end
    if (sl_ready[u]) begin
      owner[u]    = w;
      lock_own[u] = (w >= 0 && q_lock[w]) ? w : -1;
      if (w >= 0) last[u] = w;
    end
  endtask

  task automatic run_cycle();
    @(negedge clk);
    modelCheck(0);
    modelCheck(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < MAXN; i++) begin
        in_addr[u][i]  = '0;
        in_write[u][i] = 1'b0;
        in_size[u][i]  = 3'd2;
        in_trans[u][i] = 2'b00;
        in_lock[u][i]  = 1'b0;
        in_wdata[u][i] = '0;
      end
      sl_ready[u] = 1'b1;
      sl_resp[u]  = 1'b0;
      sl_rdata[u] = 32'h0;
    end
  endtask

  task automatic drive(input int u, input int i, input logic [1:0] tr, input logic [31:0] addr,
                       input logic wr, input logic lk, input logic [31:0] wd);
    in_trans[u][i] = tr;
    in_addr[u][i]  = addr;
    in_write[u][i] = wr;
    in_lock[u][i]  = lk;
    in_wdata[u][i] = wd;
  endtask

  // A master only moves on to a new request once its current one has been accepted.
  task automatic applyStimulus(input int u, input int pct);
    int r;
    for (int i = 0; i < NM[u]; i++) begin
      if (exp_rdy[u][i]) begin
        r = int'($urandom_range(99));
        if (r < pct)           in_trans[u][i] = (r % 2 == 1) ? 2'b11 : 2'b10;
        else if (r < pct + 10) in_trans[u][i] = 2'b01;
        else                   in_trans[u][i] = 2'b00;
        in_addr[u][i]  = $urandom & 32'hFFFF_FFFC;
        in_write[u][i] = 1'($urandom_range(1));
        in_size[u][i]  = 3'($urandom_range(2));
        in_lock[u][i]  = ($urandom_range(99) < 15);
      end
      in_wdata[u][i] = $urandom;
    end
    sl_ready[u] = ($urandom_range(99) < 70);
    sl_resp[u]  = ($urandom_range(99) < 15);
    sl_rdata[u] = $urandom;
  endtask

  initial begin
    int pct;
    rst_n = 1'b0;
    idle_all();
    model_reset(0);
    model_reset(1);
    repeat (2) run_cycle();
    for (int i = 0; i < MAXN; i++) drive(0, i, 2'b10, 32'h40 * (i + 1), 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < NB; i++) drive(1, i, 2'b10, 32'h80 * (i + 1), 1'b1, 1'b1, 32'h0);
    run_cycle();
    rst_n = 1'b1;
    idle_all();
    run_cycle();

    // Simultaneous requests on the fixed-priority arbiter.
    drive(0, 0, 2'b10, 32'h100, 1'b0, 1'b0, 32'h0);
    drive(0, 1, 2'b10, 32'h200, 1'b0, 1'b0, 32'h0);
    run_cycle();
    idle_all();
    repeat (3) run_cycle();

    // Continuous requests on the round-robin arbiter.
    for (int i = 0; i < NB; i++) drive(1, i, 2'b10, 32'h1000 * (i + 1), 1'b0, 1'b0, 32'h0);
    repeat (8) run_cycle();
    idle_all();
    repeat (2) run_cycle();

    // Locked sequence from master 0 while master 1 keeps requesting (round-robin).
    drive(1, 0, 2'b10, 32'h300, 1'b0, 1'b1, 32'h0);
    drive(1, 1, 2'b10, 32'h400, 1'b0, 1'b0, 32'h0);
    repeat (3) run_cycle();
    drive(1, 0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (3) run_cycle();
    idle_all();
    run_cycle();

    // Write held behind a competing read and two slave wait states.
    drive(0, 0, 2'b10, 32'h600, 1'b0, 1'b0, 32'h0);
    drive(0, 1, 2'b10, 32'h500, 1'b1, 1'b0, 32'hDEAD_BEEF);
    run_cycle();
    drive(0, 0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(0, 1, 2'b00, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
    sl_ready[0] = 1'b0;
    repeat (2) run_cycle();
    sl_ready[0] = 1'b1;
    repeat (3) run_cycle();
    idle_all();

    // Two-cycle ERROR response to a master 0 read.
    drive(0, 0, 2'b10, 32'h800, 1'b0, 1'b0, 32'h0);
    run_cycle();
    idle_all();
    sl_ready[0] = 1'b0;
    sl_resp[0]  = 1'b1;
    run_cycle();
    sl_ready[0] = 1'b1;
    run_cycle();
    sl_resp[0] = 1'b0;
    run_cycle();

    // Reset while master 1 sits in its hold register.
    sl_ready[0] = 1'b0;
    drive(0, 1, 2'b10, 32'h700, 1'b0, 1'b0, 32'h0);
    run_cycle();
    drive(0, 1, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
    run_cycle();
    rst_n = 1'b0;
    repeat (2) run_cycle();
    rst_n = 1'b1;
    idle_all();
    repeat (3) run_cycle();

    for (int c = 0; c < 3000; c++) begin
      if (c % 600 == 300) rst_n = 1'b0;
      else if (c % 600 == 302) rst_n = 1'b1;
      pct = 20 + 15 * ((c / 500) % 5);
      applyStimulus(0, pct);
      applyStimulus(1, pct);
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/raifes_hasti_arbiter.md
RAIFES_HASTI_ARBITER -- requirements
Module: raifes_hasti_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of master ports (2..8).
REQ-002 SHALL have parameter ARB_MODE, default 1, where 0 = fixed priority (index 0 highest) and 1 = round-robin.
REQ-003 SHALL have parameter AW, default 32, address width.
REQ-004 SHALL have parameter DW, default 32, data width.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 m_haddr  in  N_MASTERS*AW  per-master address, master i at bits [i*AW +: AW].
REQ-008 m_hwrite  in  N_MASTERS  per-master write flag.
REQ-009 m_hsize  in  N_MASTERS*3  per-master transfer size.
REQ-010 m_htrans  in  N_MASTERS*2  per-master transfer type.
REQ-011 m_hmastlock  in  N_MASTERS  per-master lock request.
REQ-012 m_hwdata  in  N_MASTERS*DW  per-master write data.
REQ-013 m_hrdata  out  DW  read data, broadcast to all masters.
REQ-014 m_hready  out  N_MASTERS  per-master ready.
REQ-015 m_hresp  out  N_MASTERS  per-master response (0 = OKAY, 1 = ERROR).
REQ-016 s_haddr/s_hwrite/s_hsize/s_htrans/s_hmastlock/s_hwdata  out  AW/1/3/2/1/DW  downstream slave address and data phase.
REQ-017 s_hrdata  in  DW  slave read data.
REQ-018 s_hready  in  1  slave ready.
REQ-019 s_hresp  in  1  slave response.

Function
REQ-020 Each master SHALL have its own state: IDLE, HELD or DATA.
REQ-021 A master has a live request when its m_htrans[1]=1 and its m_hready=1 in the same cycle.
REQ-022 Arbitration SHALL occur only in cycles where s_hready=1.
REQ-023 Arbitration candidates are HELD masters plus masters with a live request.
REQ-024 The winner SHALL drive the s_* address phase that cycle, from its hold register if HELD, otherwise from its live inputs.
REQ-025 The winner SHALL enter DATA on the next edge.
REQ-026 With no winner, s_htrans SHALL be IDLE (00).
REQ-027 A live request that is not granted, whether by losing or because s_hready=0, SHALL be captured into that master's hold register (haddr, hwrite, hsize, htrans, hmastlock) and the master SHALL enter HELD.
REQ-028 m_hready[i] SHALL be 0 in HELD, s_hready in DATA, and 1 in IDLE.
REQ-029 m_hresp[i] SHALL be s_hresp in DATA and 0 otherwise, so two-cycle ERROR responses pass through unchanged.
REQ-030 A data-phase owner register SHALL select s_hwdata from the owner's m_hwdata; s_hwdata SHALL be 0 when there is no owner.
REQ-031 A DATA master SHALL leave DATA when s_hready=1: to IDLE, or back to DATA if it wins a new live request in that same cycle (pipelined back-to-back transfer).
REQ-032 Fixed mode: the lowest-index candidate SHALL win.
REQ-033 Round-robin mode: the search SHALL start at (last_grant+1) mod N_MASTERS, and last_grant SHALL update on every grant.
REQ-034 Lock: once a granted transfer has hmastlock=1, only that master SHALL be eligible while it continues to request with hmastlock=1; lock releases on its first IDLE or unlocked request.
REQ-035 A master SHALL be granted at most one outstanding transfer, and the arbiter SHALL add no wait state when there is no contention and s_hready=1.
REQ-036 An IDLE or BUSY m_htrans SHALL never be captured or forwarded.

Reset
REQ-037 While reset=0, all masters SHALL be IDLE and hold registers cleared.
REQ-038 While reset=0: owner invalid, last_grant=N_MASTERS-1, lock cleared.
REQ-039 While reset=0: s_haddr=0, s_htrans=00, s_hwrite=0, s_hsize=0, s_hmastlock=0, s_hwdata=0.
REQ-040 While reset=0: m_hready all 1, m_hresp all 0.
REQ-041 Reset asserted mid-transfer SHALL abandon all held and in-flight transfers with no s_htrans pulse after deassertion.

Verification
REQ-042 N=2, fixed mode, both masters NONSEQ to 0x100/0x200 in the same cycle, slave zero-wait -> 0x100 issued in cycle 0, 0x200 in cycle 1, m_hready[1]=0 for exactly one cycle.
REQ-043 N=3, round-robin, all masters request continuously -> grant order 0,1,2,0,1,2 on s_haddr.
REQ-044 Master 0 locked sequence of 3 transfers with hmastlock=1 while master 1 requests -> master 1 issued only after master 0's unlocked or IDLE cycle.
REQ-045 Master 1 write 0xDEADBEEF held behind 2 slave wait states -> s_hwdata=0xDEADBEEF in master 1's slave data phase, and m_hready[1] rises with that s_hready.
REQ-046 Slave ERROR (s_hresp=1 for 2 cycles) on master 0 read -> m_hresp[0]=1 for 2 cycles, m_hresp[1]=0.
REQ-047 reset=0 asserted while master 1 is HELD -> after deassertion, outputs match REQ-039/REQ-040 and the held address is never issued.
